// File: rtl/gmem_lock_arbiter.sv
// gmem_lock_arbiter: two-core global memory and lock arbiter with watchdog, violation flag and stall counter.
module gmem_lock_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              need_lock_0,
    input  logic              need_lock_1,
    input  logic [ADDR_W-1:0] gaddress_0,
    input  logic [DATA_W-1:0] gdata_0,
    input  logic              gwren_0,
    input  logic [ADDR_W-1:0] gaddress_1,
    input  logic [DATA_W-1:0] gdata_1,
    input  logic              gwren_1,
    output logic              lock_0,
    output logic              lock_1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] gq,
    output logic [1:0]        owner,
    output logic              hold_timeout,
    output logic              access_violation,
    output logic [CNT_W-1:0]  stall_cycles
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, RELEASE} state_t;
    state_t r_state, w_next, w_grant;
    logic r_last, r_timeout, r_viol;
    logic [CNT_W-1:0] r_hold, r_stall, w_hold_nxt;
    logic w_own0, w_own1, w_stay, w_enter;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    // r_last=1 means core 1 held the lock last, so core 0 wins a tie
    always_comb begin
        w_grant = (need_lock_0 & need_lock_1) ? (r_last ? OWN0 : OWN1) :
                  need_lock_0 ? OWN0 : need_lock_1 ? OWN1 : IDLE;
        w_next  = r_state == OWN0 ? (need_lock_0 ? OWN0 : RELEASE) :
                  r_state == OWN1 ? (need_lock_1 ? OWN1 : RELEASE) : w_grant;
    end
    always_comb begin
        w_own0       = r_state == OWN0;
        w_own1       = r_state == OWN1;
        owner        = {w_own1, w_own0};
        lock_0       = need_lock_0 & ~w_own0;
        lock_1       = need_lock_1 & ~w_own1;
        mem_address  = w_own0 ? gaddress_0 : w_own1 ? gaddress_1 : '0;
        mem_data     = w_own0 ? gdata_0 : w_own1 ? gdata_1 : '0;
        mem_wren     = w_own0 ? gwren_0 : w_own1 ? gwren_1 : 1'b0;
        gq           = mem_q;
        hold_timeout = r_timeout;
        access_violation = r_viol;
        stall_cycles = r_stall;
    end
    always_comb begin
        w_stay     = (w_own0 & need_lock_0) | (w_own1 & need_lock_1);
        w_enter    = (w_next == OWN0 || w_next == OWN1) & ~w_stay;
        w_hold_nxt = w_stay ? (&r_hold ? r_hold : r_hold + 1'b1) : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last    <= 1'b1;
            r_hold    <= '0;
            r_timeout <= 1'b0;
            r_viol    <= 1'b0;
            r_stall   <= '0;
        end else begin
            if (w_enter) r_last <= w_next == OWN1;
            r_hold    <= w_hold_nxt;
            r_timeout <= r_timeout | (w_stay & (w_hold_nxt == CNT_W'(MAX_HOLD - 1)));
            r_viol    <= r_viol | (gwren_0 & ~w_own0) | (gwren_1 & ~w_own1);
            if ((lock_0 | lock_1) & ~&r_stall) r_stall <= r_stall + 1'b1;
        end
    end
endmodule

// File: tb/tb_gmem_lock_arbiter.sv
// tb_gmem_lock_arbiter: scoreboard bench comparing the arbiter against a cycle model of owner, flags and counters.
module tb_gmem_lock_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int CW = 16;
    logic clk = 1'b0, rst = 1'b0;
    logic need_lock_0, need_lock_1, gwren_0, gwren_1, mem_wren;
    logic lock_0, lock_1, hold_timeout, access_violation;
    logic [AW-1:0] gaddress_0, gaddress_1, mem_address;
    logic [DW-1:0] gdata_0, gdata_1, mem_data, mem_q, gq;
    logic [1:0] owner;
    logic [CW-1:0] stall_cycles;
    always #5 clk = ~clk;
    gmem_lock_arbiter dut (
        .clk(clk), .rst(rst),
        .need_lock_0(need_lock_0), .need_lock_1(need_lock_1),
        .gaddress_0(gaddress_0), .gdata_0(gdata_0), .gwren_0(gwren_0),
        .gaddress_1(gaddress_1), .gdata_1(gdata_1), .gwren_1(gwren_1),
        .lock_0(lock_0), .lock_1(lock_1),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .gq(gq), .owner(owner),
        .hold_timeout(hold_timeout), .access_violation(access_violation),
        .stall_cycles(stall_cycles)
    );
    typedef struct {
        logic          l0, l1, mw, to, av;
        logic [1:0]    own;
        logic [AW-1:0] ma;
        logic [DW-1:0] md, q;
        logic [CW-1:0] st;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0;
    int m_own, m_last, m_hold, m_stall;
    bit m_to, m_av;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask
    task automatic model_reset();
        m_own = 0; m_last = 1; m_hold = 0; m_stall = 0; m_to = 0; m_av = 0;
    endtask
    task automatic step(input bit n0, input bit n1, input bit w0, input bit w1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [DW-1:0] d0);
        exp_t e, g;
        @(negedge clk);
        need_lock_0 = n0; need_lock_1 = n1; gwren_0 = w0; gwren_1 = w1;
        gaddress_0 = a0; gaddress_1 = a1; gdata_0 = d0;
        gdata_1 = $urandom; mem_q = $urandom;
        e.l0  = n0 && m_own != 1;
        e.l1  = n1 && m_own != 2;
        e.own = 2'(m_own);
        e.ma  = m_own == 1 ? a0 : m_own == 2 ? a1 : '0;
        e.md  = m_own == 1 ? d0 : m_own == 2 ? gdata_1 : '0;
        e.mw  = m_own == 1 ? w0 : m_own == 2 ? w1 : 1'b0;
        e.q   = mem_q;
        e.to  = m_to;
        e.av  = m_av;
        e.st  = CW'(m_stall);
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chk("lock_0", 32'(lock_0), 32'(g.l0));
        chk("lock_1", 32'(lock_1), 32'(g.l1));
        chk("owner", 32'(owner), 32'(g.own));
        chk("mem_address", 32'(mem_address), 32'(g.ma));
        chk("mem_data", mem_data, g.md);
        chk("mem_wren", 32'(mem_wren), 32'(g.mw));
        chk("gq", gq, g.q);
        chk("hold_timeout", 32'(hold_timeout), 32'(g.to));
        chk("access_violation", 32'(access_violation), 32'(g.av));
        chk("stall_cycles", 32'(stall_cycles), 32'(g.st));
        @(posedge clk);
        if ((w0 && m_own != 1) || (w1 && m_own != 2)) m_av = 1;
        if ((g.l0 || g.l1) && m_stall < 65535) m_stall++;
        if ((m_own == 1 && n0) || (m_own == 2 && n1)) begin
            if (m_hold < 65535) m_hold++;
            if (m_hold == 63) m_to = 1;
        end else if (m_own != 0) begin
            m_own = 0;
        end else if (n0 || n1) begin
            m_own  = (n0 && n1) ? (m_last == 1 ? 1 : 2) : (n0 ? 1 : 2);
            m_hold = 0;
            m_last = m_own - 1;
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_timeout", 32'(hold_timeout), 32'd0);
        chk("rst_violation", 32'(access_violation), 32'd0);
        chk("rst_lock_1", 32'(lock_1), 32'(need_lock_1));
        {need_lock_0, need_lock_1, gwren_0, gwren_1} = '0;
        gaddress_0 = '0; gaddress_1 = '0; gdata_0 = '0; gdata_1 = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
    endtask
    initial begin
        {need_lock_0, need_lock_1, gwren_0, gwren_1} = '0;
        gaddress_0 = '0; gaddress_1 = '0; gdata_0 = '0; gdata_1 = '0; mem_q = '0;
        model_reset();
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 6'd5, 0, 32'hA5);
        #1;
        chk("t1_addr", 32'(mem_address), 32'd5);
        chk("t1_data", mem_data, 32'hA5);
        chk("t1_wren", 32'(mem_wren), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        repeat (4) step(1, 1, 0, 0, 6'd1, 6'd2, 32'h11);
        step(0, 1, 0, 0, 6'd1, 6'd2, 32'h11);
        step(0, 1, 0, 0, 6'd1, 6'd2, 32'h11);
        #1;
        chk("tie_owner", 32'(owner), 32'd2);
        chk("tie_stall", 32'(stall_cycles), 32'd6);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 6'd3, 6'd9, 32'h22);
        #1;
        chk("viol_wren", 32'(mem_wren), 32'd0);
        chk("viol_flag", 32'(access_violation), 32'd1);
        step(1, 0, 0, 0, 6'd3, 0, 32'h22);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("viol_sticky", 32'(access_violation), 32'd1);
        step(1, 0, 0, 0, 6'd7, 0, 32'h33);
        for (int i = 1; i <= 62; i++) step(1, 0, i[0], 0, 6'(i), 0, 32'(i));
        #1;
        chk("hold_63", 32'(hold_timeout), 32'd0);
        step(1, 0, 0, 0, 6'd7, 0, 32'h33);
        #1;
        chk("hold_64", 32'(hold_timeout), 32'd1);
        chk("hold_owner", 32'(owner), 32'd1);
        repeat (3) step(1, 0, 0, 0, 6'd7, 0, 32'h33);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("hold_sticky", 32'(hold_timeout), 32'd1);
        step(1, 0, 0, 0, 6'd4, 0, 32'h44);
        step(1, 0, 0, 0, 6'd4, 0, 32'h44);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 6'd4, 0, 32'h44);
        #1;
        chk("rereq_self", 32'(owner), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 6'd4, 6'd8, 32'h44);
        #1;
        chk("rereq_other", 32'(owner), 32'd2);
        step(0, 1, 0, 1, 0, 6'd3, 0);
        #1;
        chk("pre_rst_wren", 32'(mem_wren), 32'd1);
        do_reset();
        step(1, 1, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_tie", 32'(owner), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gmem_lock_arbiter.md
Name: gmem_lock_arbiter

Overview:
- Arbitrates the shared global data memory and its mutual-exclusion lock between core 0 and core 1 of the dual-core tiny RISC-V system.
- Takes each core's need_lock and global-memory port (gaddress/gdata/gwren), and returns a per-core lock stall input.
- Drives the single shared memory port from the current lock owner only, and broadcasts the memory read data back to both cores.
- Provides a hold-time watchdog, an unlocked-write violation flag and a stall-cycle counter for debug and verification.

Parameters:
- ADDR_W, 6, global memory address width.
- DATA_W, 32, global memory data width.
- MAX_HOLD, 64, cycles of continuous ownership at which hold_timeout sets.
- CNT_W, 16, width of stall_cycles and of the internal hold counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- need_lock_0  input  1  core 0 lock request (level).
- need_lock_1  input  1  core 1 lock request (level).
- gaddress_0  input  ADDR_W  core 0 global address.
- gdata_0  input  DATA_W  core 0 global write data.
- gwren_0  input  1  core 0 global write enable.
- gaddress_1  input  ADDR_W  core 1 global address.
- gdata_1  input  DATA_W  core 1 global write data.
- gwren_1  input  1  core 1 global write enable.
- lock_0  output  1  stall to core 0.
- lock_1  output  1  stall to core 1.
- mem_address  output  ADDR_W  shared memory address.
- mem_data  output  DATA_W  shared memory write data.
- mem_wren  output  1  shared memory write enable.
- mem_q  input  DATA_W  shared memory read data.
- gq  output  DATA_W  read data to both cores.
- owner  output  2  00 none, 01 core 0, 10 core 1.
- hold_timeout  output  1  sticky watchdog flag.
- access_violation  output  1  sticky flag: gwren from a non-owner.
- stall_cycles  output  CNT_W  saturating count of stall cycles.

Behaviour:
- States:
  - IDLE: no owner.
  - OWN0, OWN1: ownership by core 0 or core 1.
  - RELEASE: one-cycle gap with no owner.
- owner is decoded from the state.
- Grant rule (evaluated in IDLE and RELEASE):
  - Only need_lock_0 set -> OWN0; only need_lock_1 set -> OWN1.
  - Both set -> grant the core that is not last_owner.
  - Neither set -> IDLE.
  - last_owner updates on every entry into OWNx.
- OWNx stays in OWNx while need_lock_x=1. When need_lock_x=0 -> RELEASE; the requests of the other core are ignored during OWNx.
- RELEASE always lasts exactly one cycle and applies the grant rule on exit. A waiting core is therefore granted 2 edges after the owner deasserts need_lock.
- lock_i = need_lock_i AND NOT (state==OWNi), combinational. A requester stalls from the cycle it raises need_lock until the edge that grants it; lock_i=0 whenever need_lock_i=0.
- Memory mux:
  - In OWNx: mem_address, mem_data and mem_wren follow core x, combinationally.
  - In IDLE and RELEASE: all three are 0.
- gq = mem_q, combinational, to both cores.
- access_violation sets on any edge where gwren_i=1 while state!=OWNi. That write is never forwarded to memory.
- Hold counter:
  - Cleared on entry to OWNx and increments each cycle in OWNx, saturating at 2^CNT_W-1.
  - hold_timeout sets on the edge where the counter reaches MAX_HOLD-1 while still in OWNx.
  - Ownership is never revoked by the watchdog.
- stall_cycles increments on each edge where lock_0|lock_1=1, saturating at all-ones.
- Reset (asynchronous, also mid-ownership) values:
  - State IDLE, owner=0, last_owner=1 (so core 0 wins the first tie).
  - Hold counter 0, hold_timeout=0, access_violation=0, stall_cycles=0.
  - mem_address, mem_data and mem_wren are 0.
  - lock_i follows need_lock_i.
  - After reset the grant rule applies from the first edge.

Test Plan:
- Reset, then need_lock_0=1 only -> lock_0=1 for 1 cycle, owner=01 at next edge. gaddress_0=5, gdata_0=0xA5, gwren_0=1 -> mem_address=5, mem_data=0xA5, mem_wren=1.
- Both need_lock rise in the same IDLE cycle after reset -> OWN0. Drop need_lock_0 at cycle t -> RELEASE at t+1, OWN1 at t+2. lock_1=1 for exactly t+2 cycles from the request, and stall_cycles matches that count.
- Core 0 owns, core 1 asserts gwren_1=1 with gaddress_1=9 -> mem_wren stays 0, access_violation=1 and stays set until reset.
- Hold ownership for MAX_HOLD=64 cycles -> hold_timeout=1 on the 64th cycle, owner unchanged. Release -> flag remains 1.
- Core 0 owns, drops and re-requests during RELEASE while core 1 is not requesting -> OWN0 again. With core 1 also requesting -> OWN1.
- Assert rst low while in OWN1 with mem_wren=1 -> immediately owner=0, mem_wren=0, counters and flags 0. Next tie grants core 0.
